// File: rtl/time_nmr_vote.sv
// Receive end of the time-redundancy path: gathers NumReps copies sharing an ID
// and votes on them (DMR flags mismatches for retry, TMR corrects by majority).
module time_nmr_vote #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned NumReps     = 3,
  parameter int unsigned IDSize      = 4,
  parameter int unsigned LockTimeout = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IDSize-1:0]    id_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IDSize-1:0]    id_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 needs_retry_o,
  output logic                 corrected_o,
  output logic                 fault_detected_o,
  output logic                 lock_o
);
  localparam int unsigned   TW   = $clog2(LockTimeout + 1);
  localparam logic [1:0]    NREP = 2'(NumReps);
  localparam logic [TW-1:0] TMO  = TW'(LockTimeout);

  typedef enum logic {S_COLLECT, S_OUTPUT} state_e;

  state_e                    r_state, w_state_nxt;
  logic [2:0][DataWidth-1:0] r_buf, w_buf_nxt, w_cp;
  logic [1:0]                r_cnt, w_cnt_nxt, w_n;
  logic [IDSize-1:0]         r_gid, w_gid_nxt;
  logic                      r_hold_v, w_hold_v_nxt;
  logic [DataWidth-1:0]      r_hold_d, w_hold_d_nxt;
  logic [IDSize-1:0]         r_hold_id, w_hold_id_nxt;
  logic                      r_last_v, w_last_v_nxt;
  logic [IDSize-1:0]         r_last_id, w_last_id_nxt;
  logic [TW-1:0]             r_tcnt, w_tcnt_nxt;
  logic [DataWidth-1:0]      r_od, w_od_nxt;
  logic [IDSize-1:0]         r_oid, w_oid_nxt;
  logic                      r_retry, w_retry_nxt, r_corr, w_corr_nxt;
  logic                      r_fault, w_fault_nxt;

  logic w_open, w_strag, w_tmo, w_complete, w_close;
  logic w_eq01, w_eq02, w_eq12;
  logic [DataWidth-1:0] w_vdata;
  logic w_vretry, w_vcorr, w_vanom;

  assign w_open = (r_cnt != 2'd0) && (r_cnt != NREP);
  // A late copy of the group just emitted is dropped even while the next group is open.
  assign w_strag = r_last_v && (id_i == r_last_id) && ((r_cnt == 2'd0) || (id_i != r_gid));
  assign w_tmo = w_open && (r_tcnt == TMO);
  assign w_complete = valid_i && !w_strag && (r_cnt != 2'd0) && (id_i == r_gid)
                      && (r_cnt == NREP - 2'd1);
  assign w_n = w_complete ? NREP : r_cnt;

  // Vote sees the closing copy straight from the input, before it lands in r_buf.
  always_comb begin
    w_cp = r_buf;
    if (w_complete) w_cp[r_cnt] = data_i;
  end

  always_comb begin
    w_eq01   = w_cp[0] == w_cp[1];
    w_eq02   = w_cp[0] == w_cp[2];
    w_eq12   = w_cp[1] == w_cp[2];
    w_vdata  = w_cp[0];
    w_vretry = 1'b0;
    w_vcorr  = 1'b0;
    w_vanom  = 1'b0;
    if (w_n == NREP) begin
      if (NumReps == 3 && !(w_eq01 && w_eq12)) begin
        w_vanom = 1'b1;
        if (w_eq01 || w_eq02) w_vcorr = 1'b1;
        else if (w_eq12) begin
          w_vcorr = 1'b1;
          w_vdata = w_cp[1];
        end else w_vretry = 1'b1;
      end else if (NumReps == 2 && !w_eq01) begin
        w_vanom  = 1'b1;
        w_vretry = 1'b1;
      end
    end else if (w_n == 2'd2 && w_eq01) w_vcorr = 1'b1;
    else w_vretry = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_cnt_nxt     = r_cnt;
    w_gid_nxt     = r_gid;
    w_hold_v_nxt  = r_hold_v;
    w_hold_d_nxt  = r_hold_d;
    w_hold_id_nxt = r_hold_id;
    w_last_v_nxt  = r_last_v;
    w_last_id_nxt = r_last_id;
    w_tcnt_nxt    = r_tcnt;
    w_od_nxt      = r_od;
    w_oid_nxt     = r_oid;
    w_retry_nxt   = r_retry;
    w_corr_nxt    = r_corr;
    w_fault_nxt   = 1'b0;
    w_close       = 1'b0;
    if (!enable_i) begin
      w_state_nxt   = S_COLLECT;
      w_buf_nxt     = '0;
      w_cnt_nxt     = '0;
      w_gid_nxt     = '0;
      w_hold_v_nxt  = 1'b0;
      w_hold_d_nxt  = '0;
      w_hold_id_nxt = '0;
      w_last_v_nxt  = 1'b0;
      w_last_id_nxt = '0;
      w_tcnt_nxt    = '0;
      w_od_nxt      = '0;
      w_oid_nxt     = '0;
      w_retry_nxt   = 1'b0;
      w_corr_nxt    = 1'b0;
    end else if (r_state == S_COLLECT) begin
      if (valid_i) begin
        w_tcnt_nxt = '0;
        if (w_strag) w_fault_nxt = 1'b1;
        else if (r_cnt == 2'd0) begin
          w_buf_nxt[0] = data_i;
          w_gid_nxt    = id_i;
          w_cnt_nxt    = 2'd1;
        end else if (id_i == r_gid) begin
          w_buf_nxt[r_cnt] = data_i;
          w_cnt_nxt        = r_cnt + 2'd1;
          w_close          = w_complete;
          w_fault_nxt      = w_complete && w_vanom;
        end else begin
          w_hold_v_nxt  = 1'b1;
          w_hold_d_nxt  = data_i;
          w_hold_id_nxt = id_i;
          w_close       = 1'b1;
          w_fault_nxt   = 1'b1;
        end
      end else if (w_tmo) begin
        w_close     = 1'b1;
        w_fault_nxt = 1'b1;
        w_tcnt_nxt  = '0;
      end else if (w_open) w_tcnt_nxt = r_tcnt + 1'b1;
      if (w_close) begin
        w_state_nxt = S_OUTPUT;
        w_od_nxt    = w_vdata;
        w_oid_nxt   = r_gid;
        w_retry_nxt = w_vretry;
        w_corr_nxt  = w_vcorr;
      end
    end else if (ready_i) begin
      w_state_nxt   = S_COLLECT;
      w_last_id_nxt = r_gid;
      w_last_v_nxt  = 1'b1;
      if (r_hold_v) begin
        w_buf_nxt[0] = r_hold_d;
        w_gid_nxt    = r_hold_id;
        w_cnt_nxt    = 2'd1;
        w_hold_v_nxt = 1'b0;
      end else w_cnt_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_COLLECT;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_gid     <= '0;
      r_hold_v  <= 1'b0;
      r_hold_d  <= '0;
      r_hold_id <= '0;
      r_last_v  <= 1'b0;
      r_last_id <= '0;
      r_tcnt    <= '0;
      r_od      <= '0;
      r_oid     <= '0;
      r_retry   <= 1'b0;
      r_corr    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_buf     <= w_buf_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gid     <= w_gid_nxt;
      r_hold_v  <= w_hold_v_nxt;
      r_hold_d  <= w_hold_d_nxt;
      r_hold_id <= w_hold_id_nxt;
      r_last_v  <= w_last_v_nxt;
      r_last_id <= w_last_id_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_od      <= w_od_nxt;
      r_oid     <= w_oid_nxt;
      r_retry   <= w_retry_nxt;
      r_corr    <= w_corr_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign valid_o          = enable_i ? (r_state == S_OUTPUT) : valid_i;
  assign ready_o          = enable_i ? (r_state == S_COLLECT) : ready_i;
  assign data_o           = enable_i ? r_od : data_i;
  assign id_o             = enable_i ? r_oid : id_i;
  assign needs_retry_o    = enable_i && r_retry;
  assign corrected_o      = enable_i && r_corr;
  assign fault_detected_o = enable_i && r_fault;
  assign lock_o           = enable_i && (r_state == S_COLLECT) && w_open;
endmodule

// File: tb/tb_time_nmr_vote.sv
// Bench for time_nmr_vote: TMR and DMR instances share one stimulus stream, each
// checked every cycle against a copy-list model, plus directed literal cases.
module tb_time_nmr_vote;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_ni, enable_i, valid_i, ready_i;
  logic [7:0] data_i;
  logic [3:0] id_i;
  wire  [1:0] o_ready, o_valid, o_retry, o_corr, o_fault, o_lock;
  wire  [1:0][7:0] o_data;
  wire  [1:0][3:0] o_id;

  time_nmr_vote #(.DataWidth(8), .NumReps(3), .IDSize(4), .LockTimeout(4)) u_tmr (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .data_i(data_i), .id_i(id_i),
    .valid_i(valid_i), .ready_o(o_ready[0]), .data_o(o_data[0]), .id_o(o_id[0]),
    .valid_o(o_valid[0]), .ready_i(ready_i), .needs_retry_o(o_retry[0]),
    .corrected_o(o_corr[0]), .fault_detected_o(o_fault[0]), .lock_o(o_lock[0]));
  time_nmr_vote #(.DataWidth(8), .NumReps(2), .IDSize(4), .LockTimeout(4)) u_dmr (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .data_i(data_i), .id_i(id_i),
    .valid_i(valid_i), .ready_o(o_ready[1]), .data_o(o_data[1]), .id_o(o_id[1]),
    .valid_o(o_valid[1]), .ready_i(ready_i), .needs_retry_o(o_retry[1]),
    .corrected_o(o_corr[1]), .fault_detected_o(o_fault[1]), .lock_o(o_lock[1]));

  int n_checks = 0, n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: list of copies gathered so far, plus the pending result, per instance.
  bit         m_emit[2], m_hv[2], m_lastv[2], m_retry[2], m_corr[2], m_fault[2];
  int         m_n[2], m_idle[2];
  logic [7:0] m_cp[2][3], m_hd[2], m_od[2];
  logic [3:0] m_gid[2], m_hid[2], m_lastid[2], m_oid[2];

  function automatic int reps_of(int k);
    return (k == 0) ? 3 : 2;
  endfunction

  task automatic clear(int k);
    m_emit[k] = 0; m_hv[k] = 0; m_lastv[k] = 0; m_retry[k] = 0; m_corr[k] = 0;
    m_fault[k] = 0; m_n[k] = 0; m_idle[k] = 0; m_od[k] = 0; m_oid[k] = 0;
  endtask

  // Majority by counting occurrences of each value among the n copies present.
  task automatic close_group(int k, output bit anom);
    int n, reps, best, c;
    logic [7:0] bv;
    n = m_n[k]; reps = reps_of(k); best = 0; bv = m_cp[k][0];
    for (int i = 0; i < n; i++) begin
      c = 0;
      for (int j = 0; j < n; j++) if (m_cp[k][j] == m_cp[k][i]) c++;
      if (c > best) begin best = c; bv = m_cp[k][i]; end
    end
    m_od[k] = m_cp[k][0]; m_retry[k] = 0; m_corr[k] = 0; anom = 0;
    if (best == n && n == reps) ;
    else if (best >= 2 && reps == 3) begin
      m_od[k] = bv; m_corr[k] = 1; anom = (n == reps);
    end else begin
      m_retry[k] = 1; anom = (n == reps);
    end
    m_oid[k] = m_gid[k]; m_emit[k] = 1; m_idle[k] = 0;
  endtask

  task automatic step(int k);
    string nm;
    bit nf, an;
    nm = (k == 0) ? "tmr" : "dmr";
    if (!enable_i) begin
      chk({nm, ".pt_valid"}, o_valid[k], valid_i);
      chk({nm, ".pt_ready"}, o_ready[k], ready_i);
      chk({nm, ".pt_data"}, o_data[k], data_i);
      chk({nm, ".pt_id"}, o_id[k], id_i);
      chk({nm, ".pt_flags"}, {o_retry[k], o_corr[k], o_fault[k], o_lock[k]}, 0);
    end else begin
      chk({nm, ".valid"}, o_valid[k], m_emit[k]);
      chk({nm, ".ready"}, o_ready[k], !m_emit[k]);
      chk({nm, ".fault"}, o_fault[k], m_fault[k]);
      chk({nm, ".lock"}, o_lock[k], !m_emit[k] && m_n[k] > 0 && m_n[k] < reps_of(k));
      if (m_emit[k]) begin
        chk({nm, ".data"}, o_data[k], m_od[k]);
        chk({nm, ".id"}, o_id[k], m_oid[k]);
        chk({nm, ".retry"}, o_retry[k], m_retry[k]);
        chk({nm, ".corr"}, o_corr[k], m_corr[k]);
      end
    end
    if (!rst_ni || !enable_i) begin clear(k); return; end
    nf = 0;
    if (m_emit[k]) begin
      if (ready_i) begin
        m_emit[k] = 0; m_lastv[k] = 1; m_lastid[k] = m_gid[k];
        if (m_hv[k]) begin
          m_cp[k][0] = m_hd[k]; m_gid[k] = m_hid[k]; m_n[k] = 1; m_hv[k] = 0;
        end else m_n[k] = 0;
      end
    end else if (valid_i) begin
      m_idle[k] = 0;
      if (m_lastv[k] && id_i == m_lastid[k] && (m_n[k] == 0 || id_i != m_gid[k])) nf = 1;
      else if (m_n[k] == 0) begin
        m_cp[k][0] = data_i; m_gid[k] = id_i; m_n[k] = 1;
      end else if (id_i == m_gid[k]) begin
        m_cp[k][m_n[k]] = data_i; m_n[k]++;
        if (m_n[k] == reps_of(k)) begin close_group(k, an); nf = an; end
      end else begin
        m_hv[k] = 1; m_hd[k] = data_i; m_hid[k] = id_i;
        close_group(k, an); nf = 1;
      end
    end else if (m_n[k] > 0) begin
      if (m_idle[k] == 4) begin close_group(k, an); nf = 1; end
      else m_idle[k]++;
    end
    m_fault[k] = nf;
  endtask

  always @(negedge clk) if (chk_on) for (int k = 0; k < 2; k++) step(k);

  task automatic drive(bit v, logic [7:0] d, logic [3:0] id);
    valid_i = v; data_i = d; id_i = id;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_ni = 0; drive(0, 8'h00, 4'h0); rst_ni = 1;
  endtask

  task automatic expect_out(string nm, int k, logic [7:0] d, logic [3:0] id, bit r, bit c, bit f);
    chk({nm, ".valid"}, o_valid[k], 1);
    chk({nm, ".data"}, o_data[k], d);
    chk({nm, ".id"}, o_id[k], id);
    chk({nm, ".retry"}, o_retry[k], r);
    chk({nm, ".corr"}, o_corr[k], c);
    chk({nm, ".fault"}, o_fault[k], f);
  endtask

  initial begin
    logic [3:0] gid, bid;
    logic [7:0] base, bd;
    int gap;
    for (int k = 0; k < 2; k++) clear(k);
    enable_i = 1; ready_i = 1; valid_i = 0; data_i = 0; id_i = 0;
    do_reset();
    chk_on = 1;
    for (int k = 0; k < 2; k++) begin
      chk("rst.valid", o_valid[k], 0); chk("rst.data", o_data[k], 0);
      chk("rst.id", o_id[k], 0); chk("rst.ready", o_ready[k], 1);
      chk("rst.flags", {o_retry[k], o_corr[k], o_fault[k], o_lock[k]}, 0);
    end
    // Clean TMR, then single fault and triple disagreement
    repeat (3) drive(1, 8'hA5, 4'd3);
    expect_out("t1", 0, 8'hA5, 4'd3, 0, 0, 0);
    drive(0, 8'h00, 4'h0);
    drive(1, 8'h3C, 4'd5); drive(1, 8'h7C, 4'd5); drive(1, 8'h3C, 4'd5);
    expect_out("t2a", 0, 8'h3C, 4'd5, 0, 1, 1);
    drive(0, 8'h00, 4'h0);
    chk("t2a.pulse_end", o_fault[0], 0);
    drive(1, 8'h01, 4'd6); drive(1, 8'h02, 4'd6); drive(1, 8'h04, 4'd6);
    expect_out("t2b", 0, 8'h01, 4'd6, 1, 0, 1);
    drive(0, 8'h00, 4'h0);
    // DMR mismatch
    do_reset();
    drive(1, 8'h10, 4'd1); drive(1, 8'h11, 4'd1);
    expect_out("t3", 1, 8'h10, 4'd1, 1, 0, 1);
    chk("t3.tmr_lock", o_lock[0], 1);
    drive(0, 8'h00, 4'h0);
    // ID fault, carried-over beat, straggler
    do_reset();
    drive(1, 8'h77, 4'd4); drive(1, 8'h77, 4'd4); drive(1, 8'h99, 4'd6);
    expect_out("t4a", 0, 8'h77, 4'd4, 0, 1, 1);
    drive(0, 8'h00, 4'h0);
    chk("t4.held_lock", o_lock[0], 1);
    drive(1, 8'h77, 4'd4);
    chk("t4.strag_fault", o_fault[0], 1);
    drive(1, 8'h99, 4'd6); drive(1, 8'h99, 4'd6);
    expect_out("t4b", 0, 8'h99, 4'd6, 0, 0, 0);
    drive(0, 8'h00, 4'h0);
    // Timeout
    do_reset();
    drive(1, 8'h55, 4'd2);
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 4'h0);
      chk("t5.lock", o_lock[0], 1); chk("t5.novalid", o_valid[0], 0);
    end
    drive(0, 8'h00, 4'h0);
    expect_out("t5", 0, 8'h55, 4'd2, 1, 0, 1);
    drive(0, 8'h00, 4'h0);
    // Backpressure
    do_reset();
    ready_i = 0;
    repeat (3) drive(1, 8'hA1, 4'd7);
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h00, 4'h0);
      chk("t6.bp_valid", o_valid[0], 1); chk("t6.bp_data", o_data[0], 8'hA1);
      chk("t6.bp_id", o_id[0], 4'd7); chk("t6.bp_ready", o_ready[0], 0);
    end
    ready_i = 1; drive(0, 8'h00, 4'h0);
    // Reset mid-group
    drive(1, 8'h33, 4'd8); drive(1, 8'h33, 4'd8);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, 4'h0);
      chk("t6.rst_tmr", o_valid[0], 0); chk("t6.rst_dmr", o_valid[1], 0);
    end
    // Randomised groups with corruption, gaps, backpressure, resets, enable drops
    for (int g = 0; g < 400; g++) begin
      gid = 4'(g); base = 8'($urandom);
      if ($urandom_range(0, 39) == 0) begin enable_i = 0; drive(0, 8'h00, 4'h0); enable_i = 1; end
      if ($urandom_range(0, 59) == 0) do_reset();
      for (int c = 0; c < 3; c++) begin
        gap = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 1);
        for (int s = 0; s < gap; s++) begin
          ready_i = $urandom_range(0, 3) != 0;
          drive(0, 8'($urandom), 4'($urandom));
        end
        ready_i = $urandom_range(0, 3) != 0;
        bd  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : base;
        bid = ($urandom_range(0, 11) == 0) ? 4'($urandom) : gid;
        drive(1, bd, bid);
      end
    end
    // Pass-through
    enable_i = 0;
    for (int i = 0; i < 10000; i++) begin
      ready_i = 1'($urandom);
      drive(1'($urandom), 8'($urandom), 4'($urandom));
    end
    enable_i = 1; ready_i = 1;
    repeat (3) drive(1, 8'h5A, 4'd9);
    expect_out("re_en", 0, 8'h5A, 4'd9, 0, 0, 0);
    drive(0, 8'h00, 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
